// File: rtl/scan_bit_collector_if.sv
// scan_bit_collector_if: PE bottom-output bus and decoded-word handshake for the bit collector
interface scan_bit_collector_if #(
    parameter int N  = 1024,
    parameter int Q  = 6,
    parameter int IW = 9
);
    logic          bot_vld;
    logic [IW-1:0] bot_idx;
    logic [Q-1:0]  llr_e;
    logic [Q-1:0]  llr_o;
    logic          last_iter;
    logic [N-1:0]  word_data;
    logic          word_valid;
    logic          word_ready;
    modport master (
        output bot_vld, bot_idx, llr_e, llr_o, last_iter, word_ready,
        input  word_data, word_valid
    );
    modport slave (
        input  bot_vld, bot_idx, llr_e, llr_o, last_iter, word_ready,
        output word_data, word_valid
    );
endinterface

// File: rtl/scan_bit_collector.sv
// scan_bit_collector: hard-decides PE layer-0 LLR pairs into an N-bit word and hands it off; optional SCAN_EARLY_STOP_EN ends a frame when two consecutive iterations agree
module scan_bit_collector #(
    parameter int N  = 1024,
    parameter int Q  = 6,
    parameter int IW = 9
) (
    input  logic                 clk,
    input  logic                 rst,
    scan_bit_collector_if.slave  bus,
    input  logic [N-1:0]         frozen,
    output logic                 busy,
    output logic                 iter_done,
    output logic                 ovf_err,
    output logic                 early_stop
);
    typedef enum logic {COLLECT, HOLD} state_t;
    state_t        state, state_nxt;
    logic [IW-1:0] cnt;
    logic [N-1:0]  word_reg, word_nxt;
    logic          last_flag;
    logic          take, eoi, hs, last_hit, es_hit, fin;
    assign take     = state == COLLECT && bus.bot_vld;
    assign eoi      = take && cnt == IW'(N/2-1);
    assign hs       = state == HOLD && bus.word_ready;
    assign last_hit = last_flag || bus.last_iter;
    assign fin      = eoi && (last_hit || es_hit);
    // word register with the incoming pair merged in; frozen bits forced to 0, sign bit decides
    always_comb begin
        word_nxt = word_reg;
        word_nxt[{bus.bot_idx, 1'b0}] = ~frozen[{bus.bot_idx, 1'b0}] & bus.llr_e[Q-1];
        word_nxt[{bus.bot_idx, 1'b1}] = ~frozen[{bus.bot_idx, 1'b1}] & bus.llr_o[Q-1];
    end
    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= COLLECT;
        else     state <= state_nxt;
    end
    // next state: leave COLLECT on a frame-ending pair, leave HOLD on handshake
    always_comb begin
        state_nxt = state == COLLECT ? (fin ? HOLD : COLLECT) : (hs ? COLLECT : HOLD);
    end
    // outputs decoded from state; the word is shown straight from the register
    always_comb begin
        bus.word_valid = state == HOLD;
        bus.word_data  = word_reg;
        busy           = state == HOLD;
    end
    // pair counter, word assembly and final-iteration flag; all cleared by a completed handshake
    always_ff @(posedge clk) begin
        if (rst || hs) begin
            cnt       <= '0;
            word_reg  <= '0;
            last_flag <= 1'b0;
        end else if (take) begin
            cnt       <= cnt + 1'b1;
            word_reg  <= word_nxt;
            last_flag <= last_hit;
        end
    end
    // iteration-complete pulse and sticky overflow for pairs arriving while the word is held
    always_ff @(posedge clk) begin
        if (rst) begin
            iter_done <= 1'b0;
            ovf_err   <= 1'b0;
        end else begin
            iter_done <= eoi;
            ovf_err   <= ovf_err || (state == HOLD && bus.bot_vld);
        end
    end
`ifdef SCAN_EARLY_STOP_EN
    logic [N-1:0] prev_word;
    logic         first_iter;
    logic         es_q;
    assign es_hit     = !first_iter && word_nxt == prev_word;
    assign early_stop = es_q;
    // remember each non-final iteration's word; a repeat ends the frame early
    always_ff @(posedge clk) begin
        if (rst || hs) begin
            prev_word  <= '0;
            first_iter <= 1'b1;
            es_q       <= 1'b0;
        end else if (eoi && !last_hit) begin
            if (es_hit) es_q <= 1'b1;
            else begin
                prev_word  <= word_nxt;
                first_iter <= 1'b0;
            end
        end
    end
`else
    assign es_hit     = 1'b0;
    assign early_stop = 1'b0;
`endif
endmodule

// File: tb/tb_scan_bit_collector.sv
// tb_scan_bit_collector: directed checks of decisions, frozen masking, ordering, hold/overflow, multi-iteration and reset
module tb_scan_bit_collector;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] frozen = 8'h00;
    logic       busy, iter_done, ovf_err, early_stop;
    int         checks = 0;
    int         fails  = 0;
    int         le[4] = '{-3, 1, -32, 0};
    int         lo[4] = '{2, -1, 31, -5};
    scan_bit_collector_if #(.N(8), .Q(6), .IW(2)) bus();
    scan_bit_collector #(.N(8), .Q(6), .IW(2)) dut (
        .clk(clk), .rst(rst), .bus(bus), .frozen(frozen),
        .busy(busy), .iter_done(iter_done), .ovf_err(ovf_err), .early_stop(early_stop)
    );
    always #5 clk = ~clk;
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic pulse(input logic [1:0] idx, input int e, input int o, input logic last);
        bus.bot_vld   = 1'b1;
        bus.bot_idx   = idx;
        bus.llr_e     = 6'(e);
        bus.llr_o     = 6'(o);
        bus.last_iter = last;
        tick();
        bus.bot_vld   = 1'b0;
        bus.last_iter = 1'b0;
    endtask
    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask
    task automatic handshake();
        bus.word_ready = 1'b1;
        tick();
        bus.word_ready = 1'b0;
    endtask
    task automatic pattern_5a(input logic last);
        pulse(2'd0, 1, -1, 1'b0);
        pulse(2'd1, 1, -1, 1'b0);
        pulse(2'd2, -1, 1, 1'b0);
        pulse(2'd3, -1, 1, last);
    endtask
    task automatic test_reset();
        do_reset();
        checks++; if (bus.word_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b expected 0", bus.word_valid); end
        checks++; if (bus.word_data !== 8'h00) begin fails++; $display("FAIL reset_data got %h expected 00", bus.word_data); end
        checks++; if ({busy, iter_done, ovf_err, early_stop} !== 4'b0000) begin fails++; $display("FAIL reset_flags got %b expected 0000", {busy, iter_done, ovf_err, early_stop}); end
    endtask
    task automatic test_basic();
        frozen = 8'h00;
        for (int i = 0; i < 3; i++) pulse(2'(i), le[i], lo[i], 1'b1);
        checks++; if (bus.word_valid !== 1'b0) begin fails++; $display("FAIL basic_early_valid got %b expected 0", bus.word_valid); end
        pulse(2'd3, le[3], lo[3], 1'b1);
        checks++; if (bus.word_valid !== 1'b1) begin fails++; $display("FAIL basic_valid got %b expected 1", bus.word_valid); end
        checks++; if (bus.word_data !== 8'h99) begin fails++; $display("FAIL basic_data got %h expected 99", bus.word_data); end
        checks++; if (iter_done !== 1'b1 || busy !== 1'b1) begin fails++; $display("FAIL basic_done_busy got %b%b expected 11", iter_done, busy); end
        checks++; if (early_stop !== 1'b0) begin fails++; $display("FAIL basic_early_stop got %b expected 0", early_stop); end
        tick();
        checks++; if (iter_done !== 1'b0) begin fails++; $display("FAIL basic_done_pulse got %b expected 0", iter_done); end
        handshake();
        checks++; if (bus.word_valid !== 1'b0 || busy !== 1'b0 || bus.word_data !== 8'h00) begin fails++; $display("FAIL basic_release got v=%b b=%b d=%h expected v=0 b=0 d=00", bus.word_valid, busy, bus.word_data); end
    endtask
    task automatic test_frozen();
        frozen = 8'h81;
        for (int i = 0; i < 4; i++) pulse(2'(i), le[i], lo[i], 1'b1);
        checks++; if (bus.word_valid !== 1'b1 || bus.word_data !== 8'h18) begin fails++; $display("FAIL frozen_data got v=%b d=%h expected v=1 d=18", bus.word_valid, bus.word_data); end
        handshake();
        frozen = 8'h00;
    endtask
    task automatic test_out_of_order();
        int order[4] = '{3, 0, 2, 1};
        for (int i = 0; i < 4; i++) pulse(2'(order[i]), le[order[i]], lo[order[i]], 1'b1);
        checks++; if (bus.word_valid !== 1'b1 || bus.word_data !== 8'h99) begin fails++; $display("FAIL ooo_data got v=%b d=%h expected v=1 d=99", bus.word_valid, bus.word_data); end
        handshake();
    endtask
    task automatic test_hold();
        for (int i = 0; i < 4; i++) pulse(2'(i), le[i], lo[i], 1'b1);
        for (int c = 0; c < 5; c++) begin
            if (c == 2) pulse(2'd0, 1, 1, 1'b1);
            else tick();
            checks++; if (bus.word_valid !== 1'b1 || bus.word_data !== 8'h99 || busy !== 1'b1) begin fails++; $display("FAIL hold_stable cycle %0d got v=%b d=%h b=%b expected v=1 d=99 b=1", c, bus.word_valid, bus.word_data, busy); end
        end
        checks++; if (ovf_err !== 1'b1) begin fails++; $display("FAIL hold_ovf got %b expected 1", ovf_err); end
        handshake();
        checks++; if (bus.word_valid !== 1'b0 || busy !== 1'b0 || ovf_err !== 1'b1) begin fails++; $display("FAIL hold_release got v=%b b=%b o=%b expected v=0 b=0 o=1", bus.word_valid, busy, ovf_err); end
        do_reset();
        checks++; if (ovf_err !== 1'b0) begin fails++; $display("FAIL ovf_clear got %b expected 0", ovf_err); end
    endtask
    task automatic test_two_iter();
        for (int i = 0; i < 4; i++) pulse(2'(i), -1, -1, 1'b0);
        checks++; if (iter_done !== 1'b1 || bus.word_valid !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL iter1_end got d=%b v=%b b=%b expected d=1 v=0 b=0", iter_done, bus.word_valid, busy); end
        tick();
        checks++; if (iter_done !== 1'b0) begin fails++; $display("FAIL iter1_pulse got %b expected 0", iter_done); end
        pulse(2'd0, 1, -2, 1'b0);
        pulse(2'd1, -1, 1, 1'b0);
        pulse(2'd2, 5, 5, 1'b0);
        pulse(2'd3, -7, -7, 1'b1);
        checks++; if (iter_done !== 1'b1 || bus.word_valid !== 1'b1 || bus.word_data !== 8'hC6) begin fails++; $display("FAIL iter2_end got d=%b v=%b w=%h expected d=1 v=1 w=c6", iter_done, bus.word_valid, bus.word_data); end
        handshake();
    endtask
    task automatic test_rst_mid();
        pulse(2'd0, -1, -1, 1'b1);
        pulse(2'd1, -1, -1, 1'b1);
        do_reset();
        pulse(2'd0, 1, -1, 1'b0);
        pulse(2'd1, 1, -1, 1'b0);
        checks++; if (bus.word_valid !== 1'b0 || iter_done !== 1'b0) begin fails++; $display("FAIL rst_mid_no_word got v=%b d=%b expected v=0 d=0", bus.word_valid, iter_done); end
        pulse(2'd2, -1, 1, 1'b0);
        pulse(2'd3, -1, 1, 1'b1);
        checks++; if (bus.word_valid !== 1'b1 || bus.word_data !== 8'h5A) begin fails++; $display("FAIL rst_mid_word got v=%b d=%h expected v=1 d=5a", bus.word_valid, bus.word_data); end
        handshake();
    endtask
`ifdef SCAN_EARLY_STOP_EN
    task automatic test_early_stop();
        do_reset();
        pattern_5a(1'b0);
        checks++; if (bus.word_valid !== 1'b0 || early_stop !== 1'b0) begin fails++; $display("FAIL es_iter1 got v=%b e=%b expected v=0 e=0", bus.word_valid, early_stop); end
        pattern_5a(1'b0);
        checks++; if (bus.word_valid !== 1'b1 || early_stop !== 1'b1 || bus.word_data !== 8'h5A) begin fails++; $display("FAIL es_iter2 got v=%b e=%b d=%h expected v=1 e=1 d=5a", bus.word_valid, early_stop, bus.word_data); end
        tick();
        checks++; if (early_stop !== 1'b1) begin fails++; $display("FAIL es_hold got %b expected 1", early_stop); end
        handshake();
        checks++; if (early_stop !== 1'b0 || bus.word_valid !== 1'b0) begin fails++; $display("FAIL es_release got e=%b v=%b expected e=0 v=0", early_stop, bus.word_valid); end
    endtask
`else
    task automatic test_early_stop();
        do_reset();
        pattern_5a(1'b0);
        pattern_5a(1'b0);
        checks++; if (bus.word_valid !== 1'b0 || early_stop !== 1'b0) begin fails++; $display("FAIL no_es got v=%b e=%b expected v=0 e=0", bus.word_valid, early_stop); end
        do_reset();
    endtask
`endif
    initial begin
        bus.bot_vld    = 1'b0;
        bus.bot_idx    = '0;
        bus.llr_e      = '0;
        bus.llr_o      = '0;
        bus.last_iter  = 1'b0;
        bus.word_ready = 1'b0;
        tick();
        test_reset();
        test_basic();
        test_frozen();
        test_out_of_order();
        test_hold();
        test_two_iter();
        test_rst_mid();
        test_early_stop();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
